// File: rtl/cnt_sched.sv
// Shared up-counter with a two-requester round-robin arbiter.
// The winning requester owns the counter until its terminal count is reached or it withdraws.
module cnt_sched #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] LEN0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] LEN1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic             BUSY,
    output logic [WIDTH-1:0] CNT,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             owner, owner_n;   // 0: requester 0 owns the counter, 1: requester 1
    logic             last, last_n;     // requester granted most recently
    logic             gnt0_n, gnt1_n, done0_n, done1_n, busy_n;
    logic [WIDTH-1:0] cnt_n, len_r, len_n;
    logic             pick, owner_req;

    assign dbg_state = state;
    assign owner_req = owner ? REQ1 : REQ0;
    // With both requesting, the one not served last wins; otherwise the sole requester wins.
    assign pick      = (REQ0 && REQ1) ? ~last : REQ1;

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        gnt0_n  = GNT0;
        gnt1_n  = GNT1;
        done0_n = 1'b0;
        done1_n = 1'b0;
        cnt_n   = CNT;
        len_n   = len_r;
        case (state)
            S_IDLE: begin
                gnt0_n = 1'b0;
                gnt1_n = 1'b0;
                cnt_n  = '0;
                if (REQ0 || REQ1) begin
                    state_n = S_RUN;
                    owner_n = pick;
                    last_n  = pick;
                    gnt0_n  = ~pick;
                    gnt1_n  = pick;
                    len_n   = pick ? LEN1 : LEN0;
                end
            end
            S_RUN: begin
                // A withdrawn request wins over a terminal count in the same cycle.
                if (!owner_req) begin
                    state_n = S_IDLE;
                    gnt0_n  = 1'b0;
                    gnt1_n  = 1'b0;
                    cnt_n   = '0;
                end else if (CNT == len_r) begin
                    state_n = S_DONE;
                    done0_n = ~owner;
                    done1_n = owner;
                end else begin
                    cnt_n = CNT + 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                gnt0_n  = 1'b0;
                gnt1_n  = 1'b0;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            GNT0  <= 1'b0;
            GNT1  <= 1'b0;
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            BUSY  <= 1'b0;
            CNT   <= '0;
            len_r <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            GNT0  <= gnt0_n;
            GNT1  <= gnt1_n;
            DONE0 <= done0_n;
            DONE1 <= done1_n;
            BUSY  <= busy_n;
            CNT   <= cnt_n;
            len_r <= len_n;
        end
    end

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched: grant order, counting, terminal count, abort and reset behaviour.
module tb_cnt_sched;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst, req0, req1;
    logic [WIDTH-1:0] len0, len1;
    logic             gnt0, gnt1, done0, done1, busy;
    logic [WIDTH-1:0] cnt;
    logic [1:0]       dbg_state;
    logic             started = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    cnt_sched #(.WIDTH(WIDTH)) dut (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .LEN0(len0), .REQ1(req1), .LEN1(len1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1),
        .BUSY(busy), .CNT(cnt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output vector layout: {gnt0, gnt1, done0, done1, busy, cnt}
    function automatic logic [15:0] outs();
        return {7'd0, gnt0, gnt1, done0, done1, busy, cnt};
    endfunction

    function automatic logic [15:0] ev(input logic g0, input logic g1, input logic d0,
                                       input logic d1, input logic b, input logic [WIDTH-1:0] c);
        return {7'd0, g0, g1, d0, d1, b, c};
    endfunction

    task automatic expect_cyc(input string tag, input logic g0, input logic g1, input logic d0,
                              input logic d1, input logic b, input logic [WIDTH-1:0] c);
        @(negedge clk);
        check(tag, outs(), ev(g0, g1, d0, d1, b, c));
    endtask

    always @(negedge clk) begin
        if (started) check("mutex", {14'd0, gnt0 & gnt1, done0 & done1}, 16'd0);
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
        repeat (2) @(negedge clk);
        check("reset", outs(), 16'd0);
        started = 1'b1;
        rst = 1'b0;
        expect_cyc("idle_noreq", 0, 0, 0, 0, 0, 0);

        // single job, LEN0=3
        req0 = 1'b1; len0 = 4'd3;
        expect_cyc("t1_grant", 1, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) expect_cyc("t1_cnt", 1, 0, 0, 0, 1, WIDTH'(i));
        expect_cyc("t1_done", 1, 0, 1, 0, 1, 3);
        req0 = 1'b0;
        expect_cyc("t1_idle", 0, 0, 0, 0, 0, 0);

        // contention after a fresh reset
        rst = 1'b1;
        expect_cyc("t2_rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; len0 = 4'd1; len1 = 4'd1;
        expect_cyc("t2_g0", 1, 0, 0, 0, 1, 0);
        expect_cyc("t2_g0c1", 1, 0, 0, 0, 1, 1);
        expect_cyc("t2_d0", 1, 0, 1, 0, 1, 1);
        expect_cyc("t2_idle_a", 0, 0, 0, 0, 0, 0);
        expect_cyc("t2_g1", 0, 1, 0, 0, 1, 0);
        expect_cyc("t2_g1c1", 0, 1, 0, 0, 1, 1);
        expect_cyc("t2_d1", 0, 1, 0, 1, 1, 1);
        expect_cyc("t2_idle_b", 0, 0, 0, 0, 0, 0);
        expect_cyc("t2_g0_again", 1, 0, 0, 0, 1, 0);
        req0 = 1'b0; req1 = 1'b0;
        expect_cyc("t2_abort", 0, 0, 0, 0, 0, 0);

        // LEN0=0: single RUN cycle
        req0 = 1'b1; len0 = 4'd0;
        expect_cyc("t3_len0_run", 1, 0, 0, 0, 1, 0);
        expect_cyc("t3_len0_done", 1, 0, 1, 0, 1, 0);
        req0 = 1'b0;
        expect_cyc("t3_len0_idle", 0, 0, 0, 0, 0, 0);

        // LEN1=15: full range without wrap
        req1 = 1'b1; len1 = 4'd15;
        for (int v = 0; v <= 15; v++) exp_q.push_back(WIDTH'(v));
        while (exp_q.size() > 0) begin
            logic [WIDTH-1:0] e;
            e = exp_q.pop_front();
            @(negedge clk);
            check("t3_cnt15", outs(), ev(0, 1, 0, 0, 1, e));
        end
        expect_cyc("t3_done15", 0, 1, 0, 1, 1, 15);
        req1 = 1'b0;
        expect_cyc("t3_idle15", 0, 0, 0, 0, 0, 0);

        // abort beats terminal count in the same cycle
        req0 = 1'b1; len0 = 4'd0;
        expect_cyc("t4_prio_run", 1, 0, 0, 0, 1, 0);
        req0 = 1'b0;
        expect_cyc("t4_prio_idle", 0, 0, 0, 0, 0, 0);

        // abort of requester 1 at CNT=2
        req1 = 1'b1; len1 = 4'd7;
        for (int i = 0; i <= 2; i++) expect_cyc("t4_run", 0, 1, 0, 0, 1, WIDTH'(i));
        req1 = 1'b0;
        expect_cyc("t4_abort", 0, 0, 0, 0, 0, 0);
        expect_cyc("t4_no_done", 0, 0, 0, 0, 0, 0);

        // reset mid-job at CNT=5, then simultaneous requests
        req0 = 1'b1; len0 = 4'd9;
        for (int i = 0; i <= 5; i++) expect_cyc("t5_run", 1, 0, 0, 0, 1, WIDTH'(i));
        rst = 1'b1;
        expect_cyc("t5_rst", 0, 0, 0, 0, 0, 0);
        rst = 1'b0; req1 = 1'b1;
        expect_cyc("t5_rr", 1, 0, 0, 0, 1, 0);
        req0 = 1'b0; req1 = 1'b0;
        expect_cyc("t5_idle", 0, 0, 0, 0, 0, 0);

        // LEN0 change after grant ignored; non-owner toggle ignored
        req0 = 1'b1; len0 = 4'd4;
        expect_cyc("t6_grant", 1, 0, 0, 0, 1, 0);
        len0 = 4'd9; req1 = 1'b1;
        expect_cyc("t6_cnt1", 1, 0, 0, 0, 1, 1);
        req1 = 1'b0;
        for (int i = 2; i <= 4; i++) expect_cyc("t6_cnt", 1, 0, 0, 0, 1, WIDTH'(i));
        expect_cyc("t6_done", 1, 0, 1, 0, 1, 4);
        req0 = 1'b0;
        expect_cyc("t6_idle", 0, 0, 0, 0, 0, 0);

        started = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
